// File: rtl/noc_pkg.sv
// Shared NoC packet layout and transmit-FSM encoding.
// Used by the mesh top, the receive side and the tx adapter.
package noc_pkg;

  localparam int ROW_N       = 3;
  localparam int COL_M       = 3;
  localparam int PCKT_DATA_W = 8;
  localparam int ROW_W       = $clog2(ROW_N);
  localparam int COL_W       = $clog2(COL_M);
  localparam int PACKET_W    = PCKT_DATA_W + ROW_W + COL_W;

  localparam int DATA_LSB = 0;
  localparam int COL_LSB  = PCKT_DATA_W;
  localparam int ROW_LSB  = PCKT_DATA_W + COL_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CHECK = 2'd2
  } tx_state_t;

endpackage

// File: rtl/rsc_tx_queue.sv
// Small synchronous FIFO holding fully formed packets.
// Head is always visible; pointers wrap modulo depth.
module rsc_tx_queue #(
  parameter int W       = 12,
  parameter int DEPTH_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [W-1:0]       data_i,
  output logic [W-1:0]       head_o,
  output logic [DEPTH_W:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [W-1:0]       mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   count;

  // storage write, no reset needed for payload
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{DEPTH_W{1'b0}}, push_i}
             - {{DEPTH_W{1'b0}}, pop_i};
    end
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/noc_rsc_tx_adapter.sv
// Resource-side transmit adapter for one mesh NoC node:
// queues requests, injects packets, replays on overflow.
module noc_rsc_tx_adapter
  import noc_pkg::*;
#(
  parameter int ROW_N         = noc_pkg::ROW_N,
  parameter int COL_M         = noc_pkg::COL_M,
  parameter int PCKT_DATA_W   = noc_pkg::PCKT_DATA_W,
  parameter int QUEUE_DEPTH_W = 2,
  parameter int MAX_RETRY     = 3,
  localparam int RW  = $clog2(ROW_N),
  localparam int CW  = $clog2(COL_M),
  localparam int PW  = PCKT_DATA_W + RW + CW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   src_valid_i,
  output logic                   src_ready_o,
  input  logic [RW-1:0]          src_row_i,
  input  logic [CW-1:0]          src_col_i,
  input  logic [PCKT_DATA_W-1:0] src_data_i,
  output logic [PW-1:0]          pckt_o,
  output logic                   wren_o,
  input  logic                   noc_full_i,
  input  logic                   noc_ovrflw_i,
  output logic                   dest_err_o,
  output logic                   drop_o,
  output logic [QUEUE_DEPTH_W:0] pending_o
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_W;
  localparam int TW    = $clog2(MAX_RETRY + 1);

  tx_state_t state, next;

  logic [QUEUE_DEPTH_W:0] count;
  logic [PW-1:0]          head;
  logic [PW-1:0]          pkt_in;
  logic [TW-1:0]          retry;
  logic accept, bad, push, pop;
  logic load, r_inc, r_clr, drop_set;

  assign src_ready_o = (count < (QUEUE_DEPTH_W+1)'(DEPTH)) & ~rst_i;
  assign accept = src_valid_i & src_ready_o;
  assign bad    = (int'(src_row_i) >= ROW_N)
                | (int'(src_col_i) >= COL_M);
  assign push   = accept & ~bad;
  assign pkt_in = {src_row_i, src_col_i, src_data_i};

  rsc_tx_queue #(
    .W       (PW),
    .DEPTH_W (QUEUE_DEPTH_W)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pkt_in),
    .head_o  (head),
    .count_o (count)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next;
  end

  // next state and per-cycle control strobes
  always_comb begin
    next     = state;
    load     = 1'b0;
    pop      = 1'b0;
    r_inc    = 1'b0;
    r_clr    = 1'b0;
    drop_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0 && !noc_full_i) begin
          load = 1'b1;
          next = S_WRITE;
        end
      end
      S_WRITE: next = S_CHECK;
      S_CHECK: begin
        next = S_IDLE;
        if (!noc_ovrflw_i) begin
          pop   = 1'b1;
          r_clr = 1'b1;
        end else if (retry < TW'(MAX_RETRY)) begin
          r_inc = 1'b1;
        end else begin
          pop      = 1'b1;
          r_clr    = 1'b1;
          drop_set = 1'b1;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  // packet register, retry counter and status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pckt_o     <= '0;
      retry      <= '0;
      drop_o     <= 1'b0;
      dest_err_o <= 1'b0;
    end else begin
      if (load)       pckt_o <= head;
      if (r_clr)      retry  <= '0;
      else if (r_inc) retry  <= retry + 1'b1;
      drop_o     <= drop_set;
      dest_err_o <= accept & bad;
    end
  end

  assign wren_o    = (state == S_WRITE);
  assign pending_o = count;

endmodule

// File: tb/tb_noc_rsc_tx_adapter.sv
// Directed bench for noc_rsc_tx_adapter.
// Hand-computed packets, single checking task.
module tb_noc_rsc_tx_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [1:0]  src_row = '0;
  logic [1:0]  src_col = '0;
  logic [7:0]  src_data = '0;
  logic [11:0] pckt;
  logic        wren;
  logic        noc_full = 1'b0;
  logic        noc_ovrflw = 1'b0;
  logic        dest_err;
  logic        drop;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drops = 0;
  logic [11:0] wq[$];
  int          wc[$];

  noc_rsc_tx_adapter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .src_row_i    (src_row),
    .src_col_i    (src_col),
    .src_data_i   (src_data),
    .pckt_o       (pckt),
    .wren_o       (wren),
    .noc_full_i   (noc_full),
    .noc_ovrflw_i (noc_ovrflw),
    .dest_err_o   (dest_err),
    .drop_o       (drop),
    .pending_o    (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wren) begin
      wq.push_back(pckt);
      wc.push_back(cyc);
    end
    if (drop) drops++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] mk(input int r, input int c,
                                     input int d);
    return {r[1:0], c[1:0], d[7:0]};
  endfunction

  task automatic send(input int r, input int c, input int d);
    src_valid = 1'b1;
    src_row   = r[1:0];
    src_col   = c[1:0];
    src_data  = d[7:0];
    chk("send_ready", src_ready, 1);
    step(1);
    src_valid = 1'b0;
  endtask

  initial begin
    int acc;
    // reset
    step(2);
    chk("rst_ready", src_ready, 0);
    chk("rst_pending", pending, 0);
    chk("rst_wren", wren, 0);
    chk("rst_pckt", pckt, 0);
    chk("rst_drop", drop, 0);
    chk("rst_derr", dest_err, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", src_ready, 1);

    // 1: basic send
    send(1, 2, 8'hA5);
    chk("t1_pend", pending, 1);
    chk("t1_idle_wren", wren, 0);
    step(1);
    chk("t1_wren", wren, 1);
    chk("t1_pckt", pckt, 12'h6A5);
    step(1);
    chk("t1_check_wren", wren, 0);
    chk("t1_check_pend", pending, 1);
    step(1);
    chk("t1_pend_done", pending, 0);
    chk("t1_pckt_hold", pckt, 12'h6A5);

    // 2: backpressure
    wq.delete(); wc.delete();
    noc_full = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      src_valid = 1'b1;
      src_row   = 2'd0;
      src_col   = 2'(i % 3);
      src_data  = 8'(8'h10 + i);
      if (src_ready) acc++;
      step(1);
    end
    src_valid = 1'b0;
    step(2);
    chk("t2_accepted", acc, 4);
    chk("t2_ready", src_ready, 0);
    chk("t2_pend", pending, 4);
    chk("t2_no_wren", wq.size(), 0);
    noc_full = 1'b0;
    step(13);
    chk("t2_count", wq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wq.size())
        chk("t2_order", wq[i], mk(0, i % 3, 8'h10 + i));
    if (wc.size() >= 4) begin
      chk("t2_gap1", wc[1] - wc[0], 3);
      chk("t2_gap3", wc[3] - wc[2], 3);
    end
    chk("t2_pend_done", pending, 0);

    // 3: single replay
    wq.delete(); wc.delete();
    send(2, 1, 8'h3C);
    step(1);
    chk("t3_wren1", wren, 1);
    step(1);
    noc_ovrflw = 1'b1;
    step(1);
    noc_ovrflw = 1'b0;
    chk("t3_pend_kept", pending, 1);
    step(1);
    chk("t3_wren2", wren, 1);
    chk("t3_pckt2", pckt, mk(2, 1, 8'h3C));
    step(2);
    chk("t3_pend_done", pending, 0);
    chk("t3_writes", wq.size(), 2);

    // 4: retry limit then next packet
    wq.delete(); wc.delete();
    noc_full = 1'b1;
    send(1, 1, 8'h5A);
    send(0, 2, 8'hC3);
    noc_full   = 1'b0;
    noc_ovrflw = 1'b1;
    step(12);
    noc_ovrflw = 1'b0;
    chk("t4_drop", drop, 1);
    chk("t4_writes", wq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wq.size())
        chk("t4_replay", wq[i], mk(1, 1, 8'h5A));
    chk("t4_pend", pending, 1);
    step(3);
    chk("t4_pend_done", pending, 0);
    chk("t4_next_cnt", wq.size(), 5);
    if (wq.size() >= 5) chk("t4_next", wq[4], mk(0, 2, 8'hC3));
    chk("t4_drops", drops, 1);

    // 5: bad destinations
    wq.delete(); wc.delete();
    send(3, 0, 8'h11);
    chk("t5_derr_row", dest_err, 1);
    chk("t5_pend_row", pending, 0);
    step(1);
    chk("t5_derr_clr", dest_err, 0);
    send(1, 3, 8'h22);
    chk("t5_derr_col", dest_err, 1);
    step(4);
    chk("t5_no_wren", wq.size(), 0);
    chk("t5_pend", pending, 0);

    // 6: reset mid-WRITE
    send(2, 2, 8'h77);
    step(1);
    chk("t6_wren", wren, 1);
    rst = 1'b1;
    step(1);
    wq.delete(); wc.delete();
    chk("t6_wren_rst", wren, 0);
    chk("t6_pend_rst", pending, 0);
    chk("t6_ready_rst", src_ready, 0);
    rst = 1'b0;
    step(5);
    chk("t6_no_replay", wq.size(), 0);
    chk("t6_no_drop", drops, 1);
    chk("t6_pend", pending, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_rsc_tx_adapter.md
# noc_rsc_tx_adapter

Resource-side transmit adapter feeding the resource input channel of one mesh XY NoC node (`rsc_pckt_i` / `rsc_wren_i` / `noc_full_o` / `noc_ovrflw_o` for index `row*COL_M+col`). It does the following:
- accepts (destination, data) requests from a local resource over a valid/ready handshake;
- buffers them in a small queue and builds packets in the NoC format;
- injects one packet at a time, respecting the node's FIFO-full flag;
- replays any packet the node reports as overflowed, up to a retry limit.

## Interface
- ROW_N, 3, mesh rows
- COL_M, 3, mesh columns
- PCKT_DATA_W, 8, payload width
- QUEUE_DEPTH_W, 2, queue holds 2^QUEUE_DEPTH_W requests
- MAX_RETRY, 3, replays allowed per packet before drop (≥1)
- Derived: PACKET_W = PCKT_DATA_W + $clog2(ROW_N) + $clog2(COL_M)
- Packet layout: [PCKT_DATA_W-1:0] data, then column address, then row address in the MSBs

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- src_valid_i  in  1  request valid
- src_ready_o  out  1  adapter can accept
- src_row_i  in  $clog2(ROW_N)  destination row
- src_col_i  in  $clog2(COL_M)  destination column
- src_data_i  in  PCKT_DATA_W  payload
- pckt_o  out  PACKET_W  to NoC `rsc_pckt_i` slice
- wren_o  out  1  to NoC `rsc_wren_i` bit
- noc_full_i  in  1  from NoC `noc_full_o` bit
- noc_ovrflw_i  in  1  from NoC `noc_ovrflw_o` bit
- dest_err_o  out  1  one-cycle pulse: request rejected, address out of range
- drop_o  out  1  one-cycle pulse: packet dropped after MAX_RETRY replays
- pending_o  out  QUEUE_DEPTH_W+1  queue occupancy

## Operation
**Accept path**
- A transfer occurs when `src_valid_i & src_ready_o`.
- `src_ready_o = (count < 2^QUEUE_DEPTH_W) & ~rst_i`. It is derived from the registered count only, so a same-cycle pop never creates room.
- Destination with `src_row_i ≥ ROW_N` or `src_col_i ≥ COL_M`: the request is consumed (handshake completes) but not enqueued. `dest_err_o` is 1 in the next cycle.
- Valid requests are written to the queue tail as a fully formed packet.

**Transmit FSM** (states IDLE, WRITE, CHECK):
- **IDLE**: if the queue is non-empty and `noc_full_i == 0`, register `pckt_o` = head, `wren_o = 1`, and go to WRITE. Otherwise hold, with `wren_o = 0`.
- **WRITE**: `wren_o` is high for exactly this one cycle; `pckt_o` holds the head packet. Next state is CHECK, with `wren_o = 0`.
- **CHECK**: sample `noc_ovrflw_i`.
  - 0: pop the head, clear the retry counter, go to IDLE.
  - 1 and retry counter < MAX_RETRY: increment the counter, keep the head, go to IDLE (the replay obeys `noc_full_i` again).
  - 1 and retry counter == MAX_RETRY: pop the head, clear the counter, pulse `drop_o` next cycle, go to IDLE.
- `pckt_o` holds its last value outside WRITE (don't-care to the NoC, but stable for the bench).

**Arithmetic and sizing**
- Queue pointers are QUEUE_DEPTH_W bits and wrap modulo depth.
- Count is QUEUE_DEPTH_W+1 bits. A simultaneous push and pop leaves count unchanged.
- Retry counter is $clog2(MAX_RETRY+1) bits.

## Timing
- **Reset** (synchronous, high for ≥1 edge) clears:
  - state = IDLE;
  - pointers and count = 0, so `pending_o = 0`;
  - retry counter = 0;
  - `wren_o`, `dest_err_o`, `drop_o` = 0;
  - `pckt_o` = 0.

  While `rst_i` is high, `src_ready_o = 0`.
- **Reset mid-operation**: the queue is flushed and any in-flight packet is abandoned with no `drop_o`. `wren_o` is 0 from the first edge with `rst_i` high.
- **Latency**: a request accepted into an empty queue at edge t, with `noc_full_i = 0`, produces `wren_o = 1` during cycle t+1→t+2.
- **Throughput**: at most one packet per 3 cycles.
- **Full flag**: `noc_full_i` is sampled only in IDLE. If it rises during WRITE, the write still happens and overflow detection covers it.
- **Overflow window**: `noc_ovrflw_i` is meaningful only in CHECK and is ignored in every other state.
- **Simultaneous events**:
  - An accept and a CHECK pop in the same cycle are both honored.
  - `dest_err_o` and `drop_o` may pulse in the same cycle.

## Structure
- Shared package `noc_pkg` holds:
  - PACKET_W and the field-offset helper constants (data LSB, column LSB, row LSB);
  - the FSM state encoding (IDLE=0, WRITE=1, CHECK=2).

  The NoC top and the receive-side block use the same offsets.
- One sub-module: `rsc_tx_queue`, a synchronous FIFO with parameterized depth. It provides push, pop, head data, and count.
- Address check, packet assembly and the FSM live in the top.

## Test plan
1. **Basic send**: reset, then send row=1 col=2 data=0xA5 with `noc_full_i = 0`.
   - Expected: one `wren_o` pulse 1 cycle after accept, with `pckt_o = {2'd1, 2'd2, 8'hA5}`.
   - Then `pending_o` returns to 0 after CHECK.
2. **Backpressure**: hold `noc_full_i = 1`, push 5 requests.
   - Expected: 4 accepted, `src_ready_o = 0`, `pending_o = 4`, no `wren_o`.
   - Release `noc_full_i`: 4 `wren_o` pulses, 3 cycles apart, in FIFO order.
3. **Single replay**: assert `noc_ovrflw_i` in CHECK once.
   - Expected: the same packet is rewritten; `pending_o` decrements only after a clean CHECK.
4. **Retry limit**: MAX_RETRY=3, assert `noc_ovrflw_i` in every CHECK.
   - Expected: exactly 4 `wren_o` pulses for the head, then a `drop_o` pulse, and the next packet proceeds.
5. **Bad destination**: send row=3 (ROW_N=3).
   - Expected: the handshake completes, `dest_err_o` pulses next cycle, `pending_o` is unchanged, no `wren_o`.
6. **Reset mid-WRITE**: assert `rst_i` in the WRITE cycle.
   - Expected: `wren_o = 0` next cycle, `pending_o = 0`, and no replay after reset is released.
